// File: rtl/pll_clken_gen.sv
// pll_clken_gen: qualifies PLL lock, releases per-channel resets in staggered order
// and generates phase-offset clock-enable pulse trains in the PLL output clock domain.
module pll_clken_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int RST_STAGGER = 16,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked_in,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic                    clear_lost,
  output logic [NUM_CH-1:0]       clken,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic                    ready,
  output logic                    lost_lock
);
  localparam int CMAX = LOCK_CYCLES > RST_STAGGER ? LOCK_CYCLES : RST_STAGGER;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RELEASE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic lk;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d, clken_q, clken_d;
  logic ready_q, ready_d, lost_q, lost_d;
  logic [NUM_CH-1:0][DIV_W-1:0] sdiv_q, sdiv_d, sph_q, sph_d, div_q, div_d, dc_q, dc_d;
  assign lk = sync_q[1];
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      cnt_q    <= '0;
      ch_rst_q <= '1;
      clken_q  <= '0;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
      sdiv_q   <= {NUM_CH{DEF}};
      sph_q    <= '0;
      div_q    <= {NUM_CH{DEF}};
      dc_q     <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], locked_in};
      cnt_q    <= cnt_d;
      ch_rst_q <= ch_rst_d;
      clken_q  <= clken_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
      sdiv_q   <= sdiv_d;
      sph_q    <= sph_d;
      div_q    <= div_d;
      dc_q     <= dc_d;
    end
  // Releases clear the lowest still-asserted reset bit, giving strict ascending order.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_rst_d = ch_rst_q;
    ready_d  = ready_q;
    lost_d   = clear_lost ? 1'b0 : lost_q;
    case (state_q)
      WAIT_LOCK: begin
        ch_rst_d = '1;
        ready_d  = 1'b0;
        cnt_d    = '0;
        state_d  = lk ? SETTLE : WAIT_LOCK;
      end
      SETTLE: begin
        if (!lk) state_d = WAIT_LOCK;
        else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d  = RELEASE;
          cnt_d    = '0;
          ch_rst_d = ch_rst_q & (ch_rst_q - NUM_CH'(1));
        end else cnt_d = cnt_q + CW'(1);
      end
      RELEASE, RUN: begin
        if (!lk) begin
          state_d  = WAIT_LOCK;
          ch_rst_d = '1;
          ready_d  = 1'b0;
          lost_d   = 1'b1;
        end else if (state_q == RELEASE) begin
          if (ch_rst_q == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else if (cnt_q == CW'(RST_STAGGER - 1)) begin
            cnt_d    = '0;
            ch_rst_d = ch_rst_q & (ch_rst_q - NUM_CH'(1));
          end else cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end
  // A channel in (or entering) reset tracks the shadow continuously; a running one only at wrap.
  always_comb begin
    sdiv_d  = cfg_load ? cfg_div : sdiv_q;
    sph_d   = cfg_load ? cfg_phase : sph_q;
    div_d   = div_q;
    dc_d    = dc_q;
    clken_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = (ch_rst_q[i] || ch_rst_d[i] || dc_q[i] == div_q[i]) ? sdiv_d[i] : div_q[i];
      dc_d[i]    = (ch_rst_q[i] || ch_rst_d[i]) ? (sph_d[i] > sdiv_d[i] ? sdiv_d[i] : sph_d[i]) :
                   dc_q[i] == div_q[i] ? '0 : dc_q[i] + DIV_W'(1);
      clken_d[i] = !ch_rst_d[i] && dc_d[i] == div_d[i];
    end
  end
  assign clken     = clken_q;
  assign ch_rst    = ch_rst_q;
  assign ready     = ready_q;
  assign lost_lock = lost_q;
endmodule

// File: tb/tb_pll_clken_gen.sv
// tb_pll_clken_gen: directed stimulus pushes per-cycle expectations into a scoreboard;
// a negedge monitor compares every expectation whose cycle has arrived.
module tb_pll_clken_gen;
  logic refclk, rst, locked_in, cfg_load, clear_lost;
  logic [63:0] cfg_div, cfg_phase;
  logic [3:0] clken, ch_rst;
  logic ready, lost_lock;
  typedef struct {int cyc; int kind; logic [31:0] val;} rec_t;
  rec_t sb[$];
  int cyc, total, bad;
  int b, c, d, e, f, g, h;
  string nm[5] = '{"clken", "ch_rst", "ready", "lost_lock", "clken0"};

  pll_clken_gen #(.NUM_CH(4), .DIV_W(16), .LOCK_CYCLES(8), .RST_STAGGER(4), .DEFAULT_DIV(0)) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .cfg_load(cfg_load), .clear_lost(clear_lost), .clken(clken), .ch_rst(ch_rst),
    .ready(ready), .lost_lock(lost_lock));

  initial begin
    refclk = 0;
    forever #5 refclk = ~refclk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge refclk);
      cyc++;
    end
  end

  function automatic logic pulse(int t, int r, int dv, int p);
    int m;
    m = p > dv ? dv : p;
    return t >= r && ((t - r + m) % (dv + 1)) == dv;
  endfunction

  function automatic logic [31:0] act(int k);
    case (k)
      0: return {28'd0, clken};
      1: return {28'd0, ch_rst};
      2: return {31'd0, ready};
      3: return {31'd0, lost_lock};
      default: return {31'd0, clken[0]};
    endcase
  endfunction

  task automatic push(int t, int k, logic [31:0] v);
    sb.push_back('{cyc: t, kind: k, val: v});
  endtask

  task automatic push_all(int t, logic [3:0] ck, logic [3:0] cr, logic rd, logic ll);
    push(t, 0, {28'd0, ck});
    push(t, 1, {28'd0, cr});
    push(t, 2, {31'd0, rd});
    push(t, 3, {31'd0, ll});
  endtask

  task automatic go(int t);
    while (cyc < t) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor: compares every due expectation at the falling edge, away from the active edge.
  initial forever begin
    @(negedge refclk);
    begin
      int k;
      k = 0;
      while (k < sb.size()) begin
        if (sb[k].cyc <= cyc) begin
          total++;
          if (sb[k].cyc < cyc) begin
            bad++;
            $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", nm[sb[k].kind], sb[k].cyc, cyc);
          end else if (act(sb[k].kind) !== sb[k].val) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm[sb[k].kind], cyc, act(sb[k].kind), sb[k].val);
          end
          sb.delete(k);
        end else k++;
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1; locked_in = 0; cfg_load = 0; clear_lost = 0;
    cfg_div = '0; cfg_phase = '0;
    push_all(1, 4'h0, 4'hF, 0, 0);
    push_all(2, 4'h0, 4'hF, 0, 0);
    go(3);
    rst = 0;
    push_all(4, 4'h0, 4'hF, 0, 0);
    push_all(5, 4'h0, 4'hF, 0, 0);
    go(5);
    cfg_div = {16'd4, 16'd0, 16'd3, 16'd3};
    cfg_phase = {16'd9, 16'd0, 16'd2, 16'd0};
    cfg_load = 1;
    go(6);
    cfg_load = 0;
    // Lock-up with staggered release and phase-offset dividers
    go(8);
    b = cyc;
    locked_in = 1;
    for (int t = b + 10; t <= b + 26; t++) begin
      push(t, 0, {28'd0, pulse(t, b + 23, 4, 9), pulse(t, b + 19, 0, 0), pulse(t, b + 15, 3, 2), pulse(t, b + 11, 3, 0)});
      push(t, 1, {28'd0, t < b + 23, t < b + 19, t < b + 15, t < b + 11});
      push(t, 2, {31'd0, t >= b + 24});
    end
    push(b + 24, 3, 32'd0);
    // Live reconfig of ch0 from D=3 to D=1 one cycle after a wrap
    go(b + 27);
    for (int t = b + 27; t <= b + 40; t++)
      push(t, 4, {31'd0, t <= b + 30 ? ((t - b - 14) % 4 == 0) : ((t - b - 30) % 2 == 0)});
    cfg_div = {16'd4, 16'd0, 16'd3, 16'd1};
    cfg_load = 1;
    go(b + 28);
    cfg_load = 0;
    // Lock loss in RUN, relock, then clear_lost
    go(b + 41);
    c = cyc;
    locked_in = 0;
    push_all(c + 2, 4'hx, 4'h0, 1, 0);
    sb.delete(sb.size() - 4);
    push_all(c + 3, 4'h0, 4'hF, 0, 1);
    go(c + 5);
    d = cyc;
    locked_in = 1;
    push(d + 10, 1, 32'hF);
    push(d + 11, 1, 32'hE);
    push(d + 23, 1, 32'h0);
    push(d + 23, 2, 32'd0);
    push(d + 24, 2, 32'd1);
    push(d + 24, 3, 32'd1);
    go(d + 26);
    e = cyc;
    clear_lost = 1;
    push(e, 3, 32'd1);
    push(e + 1, 3, 32'd0);
    go(e + 1);
    clear_lost = 0;
    // Lock loss coinciding with clear_lost: set wins
    go(e + 2);
    f = cyc;
    locked_in = 0;
    push_all(f + 3, 4'h0, 4'hF, 0, 1);
    push(f + 4, 3, 32'd1);
    go(f + 2);
    clear_lost = 1;
    go(f + 3);
    clear_lost = 0;
    // Async reset in the middle of RELEASE
    go(f + 5);
    g = cyc;
    locked_in = 1;
    push_all(g + 12, 4'h1, 4'hE, 0, 1);
    push_all(g + 13, 4'h0, 4'hF, 0, 0);
    go(g + 13);
    #1;
    rst = 1;
    locked_in = 0;
    go(g + 15);
    rst = 0;
    // Lock glitch during SETTLE restarts qualification
    go(g + 17);
    h = cyc;
    locked_in = 1;
    push(h + 11, 1, 32'hF);
    push(h + 17, 1, 32'hF);
    push(h + 17, 2, 32'd0);
    push(h + 18, 1, 32'hE);
    go(h + 6);
    locked_in = 0;
    go(h + 7);
    locked_in = 1;
    go(h + 22);
    @(negedge refclk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d need=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_clken_gen.md
# pll_clken_gen

Parametrised clock-enable and reset sequencer that sits directly downstream of a core PLL wrapper and runs on the PLL output clock. It qualifies the PLL `locked` indication, releases per-channel synchronous resets in a staggered order, and generates NUM_CH independently programmable, phase-offset clock-enable pulse trains. It replaces fixed extra PLL output frequencies with enables, so there is one clock domain. Loss of lock returns every channel to reset and raises a sticky flag.

## Interface
- NUM_CH, 4, number of enable/reset channels (1..16)
- DIV_W, 16, width of per-channel divide and phase values
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before release (>=1)
- RST_STAGGER, 16, cycles between successive channel reset releases (>=1)
- DEFAULT_DIV, 0, reset value of every channel's divide register

Ports:
- refclk  in  1  sole clock (PLL output clock)
- rst  in  1  asynchronous, active-high reset
- locked_in  in  1  PLL locked; asynchronous, synchronised internally by 2 flops
- cfg_div  in  NUM_CH*DIV_W  per-channel divide; channel i at bits [i*DIV_W +: DIV_W]
- cfg_phase  in  NUM_CH*DIV_W  per-channel phase offset, same packing
- cfg_load  in  1  single-cycle pulse; captures cfg_div/cfg_phase into shadow registers
- clear_lost  in  1  clears lost_lock
- clken  out  NUM_CH  per-channel clock-enable pulses
- ch_rst  out  NUM_CH  per-channel synchronous reset, active high
- ready  out  1  high only in RUN
- lost_lock  out  1  sticky: lock dropped while in RELEASE or RUN

## Operation
- Reset values: clken=0, ch_rst=all 1, ready=0, lost_lock=0, state=WAIT_LOCK, shadow/active div=DEFAULT_DIV, phase=0.
- `lk` denotes synchronised locked_in.
- WAIT_LOCK: ch_rst all 1, clken 0. On lk=1 -> SETTLE with settle count 0.
- SETTLE: count increments each cycle lk=1. On lk=0 -> WAIT_LOCK. When count==LOCK_CYCLES-1 -> RELEASE.
- RELEASE: ch_rst[0] drops on the first RELEASE cycle. ch_rst[i] drops RST_STAGGER*i cycles later. Release is ascending order only, and a released channel stays released. RUN is entered on the cycle after ch_rst[NUM_CH-1] drops.
- RUN: ready=1. Everything holds until lk=0.
- lk=0 in RELEASE or RUN, same cycle detected: next cycle ch_rst all 1, clken 0, ready 0, lost_lock=1, state WAIT_LOCK. lost_lock clears only on clear_lost. If lk=0 and clear_lost occur together, set wins.
- Divider, per channel, with active div D and active phase P:
  - While ch_rst[i]=1, the counter is held at min(P,D).
  - After release, the counter increments modulo D+1.
  - clken[i] pulses for one cycle when the counter equals D, giving a period of D+1 cycles.
  - D=0 means clken[i] is constant 1 while released.
  - Counter arithmetic is DIV_W bits unsigned. P>D is clamped to D.
- Config:
  - cfg_load copies all channels into the shadow registers.
  - Shadow to active transfer happens immediately for a channel while its ch_rst=1.
  - A released channel transfers only on the cycle its counter wraps (the clken cycle), so no runt or stretched periods occur. The counter then restarts at 0 with the new D; phase is ignored on a running channel.
  - cfg_load on the same cycle as a wrap: the newly loaded value takes effect at that wrap.

## Timing
- lk lags locked_in by 2 refclk cycles.
- locked_in rises at cycle 0 and stays high: first RELEASE cycle is 3+LOCK_CYCLES. ch_rst[i] is low from cycle 3+LOCK_CYCLES+RST_STAGGER*i. ready rises at 4+LOCK_CYCLES+RST_STAGGER*(NUM_CH-1).
- First clken[i] is (D−min(P,D)) cycles after ch_rst[i] first reads 0. With D=0 it is high in the same cycle ch_rst[i] first reads 0.
- All outputs are registered. No combinational path from any input to any output.
- Asynchronous rst mid-operation returns every register to its reset value immediately.

## Test plan
- Lock-up, NUM_CH=4, LOCK_CYCLES=8, RST_STAGGER=4, locked_in high at cycle 0 -> ch_rst drops at cycles 11/15/19/23, ready=1 at cycle 24, lost_lock=0.
- Lock glitch in SETTLE: locked_in low for 1 cycle at cycle 6 -> settle count restarts, no ch_rst release before a fresh 8 consecutive lk cycles.
- Divider/phase: ch0 D=3 P=0, ch1 D=3 P=2, ch2 D=0, ch3 D=4 P=9 -> ch0 first pulse 3 cycles after release then every 4; ch1 1 cycle after release; ch2 constant 1; ch3 P clamped so first pulse at release, period 5.
- Live reconfig: ch0 running D=3, cfg_load D=1 mid-period -> current 4-cycle period completes, then period 2. No pulse spacing other than 4 or 2.
- Lock loss in RUN: locked_in low -> 3 cycles later ch_rst all 1, clken 0, ready 0, lost_lock 1. Relock re-sequences fully. clear_lost pulse -> lost_lock 0.
- Async rst asserted mid-RELEASE -> all outputs at reset values before the next refclk edge.
